seq_power_seq: RTL and testbench
================================

Name: seq_power_seq

Overview:
- Parametrised successor to the CPU sequencer's clock, oscillator and memory-strobe control.
- Generates the T-state phase within each M-cycle and drives MREQ/RD/WR strobes, with MEM_WAIT extension.
- Runs the HALT and STOP low-power state machine: masked multi-source wake, oscillator re-enable, then a counted stabilisation delay before CLK_ENA returns.
- Sits between the instruction decoder (request inputs) and the clock/pad logic.

Parameters:
- TSTATES, 4: T-states per M-cycle; minimum 3.
- NUM_WAKE, 5: number of wake/interrupt sources.
- OSC_WAIT_CYCLES, 16: consecutive OSC_STABLE-high cycles required before the clock resumes after STOP; minimum 1.
- WAIT_MAX, 8: maximum stall cycles per access (only with SEQ_WAIT_TIMEOUT_EN).

Ports:
- CLK, in, 1: the single clock; all state changes on its rising edge.
- RESET, in, 1: synchronous, active-high reset.
- HALT_REQ, in, 1: decoder HALT request.
- STOP_REQ, in, 1: decoder STOP request.
- MEM_ACCESS, in, 1: the next M-cycle performs a bus access.
- MEM_WRITE, in, 1: that access is a write.
- MEM_WAIT, in, 1: external wait request.
- WAKE, in, NUM_WAKE: wake/interrupt sources.
- WAKE_MASK, in, NUM_WAKE: per-source enable.
- OSC_STABLE, in, 1: oscillator-stable indication.
- CLK_ENA, out, 1: CPU core clock enable.
- OSC_ENA, out, 1: oscillator enable.
- MREQ, out, 1: memory request strobe.
- RD, out, 1: read strobe.
- WR, out, 1: write strobe.
- TSTATE, out, TSTATES: one-hot phase.
- M_LAST, out, 1: last T-state of the M-cycle.
- WAKE_ID, out, clog2(NUM_WAKE): index of the wake source that was taken.
- STATE, out, 3: FSM state, for debug.
- WAIT_TIMEOUT, out, 1: sticky stall-timeout flag.

Behaviour:
- Reset values: STATE=RUN, T=0 (TSTATE=1), CLK_ENA=1, OSC_ENA=1, MREQ=RD=WR=0, M_LAST=0, WAKE_ID=0, WAIT_TIMEOUT=0, all counters 0.
  - RESET wins over every other input in the same cycle, including in the middle of a stall, HALT, STOP or OSC_WAIT.
- FSM states: RUN=0, HALT=1, STOP=2, OSC_WAIT=3.
- T counter (RUN only):
  - Advances 0..TSTATES-1 and wraps to 0 when not stalled.
  - M_LAST=1 while T=TSTATES-1.
  - Frozen in every other state.
- Access sampling: MEM_ACCESS and MEM_WRITE are sampled at T=0 into a registered access/write pair.
- Strobes for a sampled access, all registered:
  - MREQ high during T=1..TSTATES-1.
  - RD = MREQ & ~write.
  - WR high during T=2..TSTATES-1 for writes only.
  - All strobes low in HALT, STOP and OSC_WAIT.
- Stall:
  - While T=TSTATES-2, an access is active and MEM_WAIT=1, T holds and the strobes hold.
  - When MEM_WAIT falls, T advances on the next edge.
  - MEM_WAIT is ignored when no access is active.
- RUN→STOP / RUN→HALT:
  - Taken only at the wrap from T=TSTATES-1 to 0, and never in the middle of a stall.
  - STOP_REQ has priority over HALT_REQ when both are high.
- Wake condition: wake = |(WAKE & WAKE_MASK).
  - WAKE_ID latches the lowest set masked index on the wake edge.
- HALT:
  - CLK_ENA=0 from the first HALT cycle.
  - When wake=1: next state RUN, CLK_ENA=1 on the same edge.
  - If wake is already 1 on the entry edge, HALT lasts exactly one cycle.
- STOP:
  - CLK_ENA=0 and OSC_ENA=0.
  - When wake=1: next state OSC_WAIT, OSC_ENA=1, stabilisation counter cleared.
- OSC_WAIT:
  - CLK_ENA=0.
  - The counter increments on each cycle with OSC_STABLE=1 and clears to 0 on any cycle with OSC_STABLE=0.
  - When the counter equals OSC_WAIT_CYCLES-1 with OSC_STABLE=1: next state RUN, CLK_ENA=1.
  - Wake inputs are ignored in this state.
- Mask change while in HALT or STOP takes effect in the same cycle: the mask is combinational into the wake condition.
- Counter widths are clog2 of their maximum value plus 1; counters never wrap.

Optional Feature:
- Macro: SEQ_WAIT_TIMEOUT_EN.
- Defined:
  - A stall counter increments each stall cycle.
  - When it reaches WAIT_MAX, T advances regardless of MEM_WAIT and WAIT_TIMEOUT sets; it stays set until RESET.
  - The stall counter clears at every T=0.
- Undefined:
  - Stalls are unbounded.
  - WAIT_TIMEOUT is tied to 0 and no stall counter is built.

Test Plan:
1. Reset, then MEM_ACCESS=1, MEM_WRITE=0 at T=0 (defaults) -> TSTATE=1,2,4,8 repeating; MREQ=RD=1 during T1–T3; WR=0; M_LAST at T3.
2. Write access with MEM_WAIT=1 for 3 cycles at T=2 -> T stays at 2 for 4 cycles total; WR high from T2 through T3; access completes in 7 cycles.
3. HALT_REQ=1 at T=3, WAKE=5'b10100, WAKE_MASK=5'b00100 after 10 cycles -> CLK_ENA=0 for 10 cycles, then 1; WAKE_ID=2; STATE returns to 0.
4. STOP_REQ and HALT_REQ both high -> STATE=2, OSC_ENA=0. Then WAKE[0] with mask bit set -> OSC_ENA=1. Then OSC_STABLE high 5 cycles, low 1, high 16 -> CLK_ENA=1 only after 16 consecutive stable cycles.
5. RESET asserted mid-OSC_WAIT, and mid-stall -> next edge STATE=0, T=0, CLK_ENA=1, OSC_ENA=1, strobes 0.
6. With SEQ_WAIT_TIMEOUT_EN, WAIT_MAX=8 and MEM_WAIT held high -> T advances after 8 stall cycles; WAIT_TIMEOUT=1 and remains 1 until RESET. Without the macro -> T stalls indefinitely and WAIT_TIMEOUT=0.

Source files
------------

// File: rtl/seq_power_seq.sv
// Sequencer clock/oscillator/strobe control: T-state phase, MREQ/RD/WR, HALT/STOP wake.
// Optional bounded stalls under `SEQ_WAIT_TIMEOUT_EN (otherwise MEM_WAIT stalls indefinitely).
module seq_power_seq #(
    parameter int TSTATES         = 4,
    parameter int NUM_WAKE        = 5,
    parameter int OSC_WAIT_CYCLES = 16,
    parameter int WAIT_MAX        = 8,
    localparam int WID_W          = (NUM_WAKE > 1) ? $clog2(NUM_WAKE) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                HALT_REQ,
    input  logic                STOP_REQ,
    input  logic                MEM_ACCESS,
    input  logic                MEM_WRITE,
    input  logic                MEM_WAIT,
    input  logic [NUM_WAKE-1:0] WAKE,
    input  logic [NUM_WAKE-1:0] WAKE_MASK,
    input  logic                OSC_STABLE,
    output logic                CLK_ENA,
    output logic                OSC_ENA,
    output logic                MREQ,
    output logic                RD,
    output logic                WR,
    output logic [TSTATES-1:0]  TSTATE,
    output logic                M_LAST,
    output logic [WID_W-1:0]    WAKE_ID,
    output logic [2:0]          STATE,
    output logic                WAIT_TIMEOUT
);

    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_HALT     = 3'd1;
    localparam logic [2:0] S_STOP     = 3'd2;
    localparam logic [2:0] S_OSC_WAIT = 3'd3;

    localparam int T_W  = $clog2(TSTATES - 1) + 1;
    localparam int OC_W = $clog2(OSC_WAIT_CYCLES - 1) + 1;

    localparam logic [T_W-1:0]  T_LAST   = T_W'(TSTATES - 1);
    localparam logic [T_W-1:0]  T_STALL  = T_W'(TSTATES - 2);
    localparam logic [OC_W-1:0] OSC_LAST = OC_W'(OSC_WAIT_CYCLES - 1);

    function automatic logic [WID_W-1:0] lowest_idx(input logic [NUM_WAKE-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_WAKE - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = WID_W'(i);
        end
    endfunction

    logic [2:0]       state, state_n;
    logic [T_W-1:0]   t, t_n;
    logic [OC_W-1:0]  osc_cnt, osc_cnt_n;
    logic             acc, acc_n;
    logic             wr_q, wr_n;
    logic [WID_W-1:0] wake_id, wake_id_n;
    logic             wake;
    logic             wait_hit;
    logic             stall;
    logic             run_n;
    logic             mreq_n, rd_n, wrs_n;

    // Wait is only meaningful at the stall point of an active access.
    assign wait_hit = (state == S_RUN) && (t == T_STALL) && acc && MEM_WAIT;

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam int WT_W = $clog2(WAIT_MAX) + 1;
    localparam logic [WT_W-1:0] WT_MAX = WT_W'(WAIT_MAX);

    logic [WT_W-1:0] stall_cnt;
    logic            timed_out;
    logic            timeout_q;

    assign timed_out = (stall_cnt == WT_MAX);
    assign stall     = wait_hit && !timed_out;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_RUN && t == '0)
                stall_cnt <= '0;
            else if (stall)
                stall_cnt <= stall_cnt + WT_W'(1);
            if (wait_hit && timed_out)
                timeout_q <= 1'b1;
        end
    end

    assign WAIT_TIMEOUT = timeout_q;
`else
    localparam int unused_wait_max = WAIT_MAX;

    assign stall        = wait_hit;
    assign WAIT_TIMEOUT = 1'b0;
`endif

    assign wake = |(WAKE & WAKE_MASK);

    always_comb begin
        state_n   = state;
        t_n       = t;
        acc_n     = acc;
        wr_n      = wr_q;
        osc_cnt_n = osc_cnt;
        wake_id_n = wake_id;
        case (state)
            S_RUN: begin
                if (t == '0) begin
                    acc_n = MEM_ACCESS;
                    wr_n  = MEM_WRITE;
                end
                if (!stall) begin
                    if (t == T_LAST) begin
                        t_n = '0;
                        if (STOP_REQ)      state_n = S_STOP;
                        else if (HALT_REQ) state_n = S_HALT;
                    end else begin
                        t_n = t + T_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (wake) begin
                    state_n   = S_RUN;
                    wake_id_n = lowest_idx(WAKE & WAKE_MASK);
                end
            end
            S_STOP: begin
                if (wake) begin
                    state_n   = S_OSC_WAIT;
                    osc_cnt_n = '0;
                    wake_id_n = lowest_idx(WAKE & WAKE_MASK);
                end
            end
            S_OSC_WAIT: begin
                if (!OSC_STABLE)
                    osc_cnt_n = '0;
                else if (osc_cnt == OSC_LAST)
                    state_n = S_RUN;
                else
                    osc_cnt_n = osc_cnt + OC_W'(1);
            end
            default: state_n = S_RUN;
        endcase
    end

    // Strobes are registered from next-state values so they line up with TSTATE.
    assign run_n  = (state_n == S_RUN);
    assign mreq_n = run_n && acc_n && (t_n != '0);
    assign rd_n   = mreq_n && !wr_n;
    assign wrs_n  = run_n && acc_n && wr_n && (t_n >= T_W'(2));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_RUN;
            t       <= '0;
            osc_cnt <= '0;
            acc     <= 1'b0;
            wr_q    <= 1'b0;
            wake_id <= '0;
            CLK_ENA <= 1'b1;
            OSC_ENA <= 1'b1;
            MREQ    <= 1'b0;
            RD      <= 1'b0;
            WR      <= 1'b0;
        end else begin
            state   <= state_n;
            t       <= t_n;
            osc_cnt <= osc_cnt_n;
            acc     <= acc_n;
            wr_q    <= wr_n;
            wake_id <= wake_id_n;
            CLK_ENA <= run_n;
            OSC_ENA <= (state_n != S_STOP);
            MREQ    <= mreq_n;
            RD      <= rd_n;
            WR      <= wrs_n;
        end
    end

    assign TSTATE  = TSTATES'(1) << t;
    assign M_LAST  = (t == T_LAST);
    assign WAKE_ID = wake_id;
    assign STATE   = state;

endmodule

// File: tb/tb_seq_power_seq.sv
// Directed bench for seq_power_seq with default parameters (TSTATES=4, NUM_WAKE=5).
module tb_seq_power_seq;

    logic       CLK = 1'b0;
    logic       RESET, HALT_REQ, STOP_REQ, MEM_ACCESS, MEM_WRITE, MEM_WAIT, OSC_STABLE;
    logic [4:0] WAKE, WAKE_MASK;
    logic       CLK_ENA, OSC_ENA, MREQ, RD, WR, M_LAST, WAIT_TIMEOUT;
    logic [3:0] TSTATE;
    logic [2:0] WAKE_ID;
    logic [2:0] STATE;

    int tests = 0;
    int fails = 0;

    seq_power_seq dut (
        .CLK(CLK), .RESET(RESET), .HALT_REQ(HALT_REQ), .STOP_REQ(STOP_REQ),
        .MEM_ACCESS(MEM_ACCESS), .MEM_WRITE(MEM_WRITE), .MEM_WAIT(MEM_WAIT),
        .WAKE(WAKE), .WAKE_MASK(WAKE_MASK), .OSC_STABLE(OSC_STABLE),
        .CLK_ENA(CLK_ENA), .OSC_ENA(OSC_ENA), .MREQ(MREQ), .RD(RD), .WR(WR),
        .TSTATE(TSTATE), .M_LAST(M_LAST), .WAKE_ID(WAKE_ID), .STATE(STATE),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {STATE, CLK_ENA, OSC_ENA, TSTATE, MREQ, RD, WR, M_LAST}
    function automatic logic [31:0] snap();
        return {19'd0, STATE, CLK_ENA, OSC_ENA, TSTATE, MREQ, RD, WR, M_LAST};
    endfunction

    function automatic logic [31:0] exp_v(input logic [2:0] st, input logic ce, input logic oe,
                                          input logic [3:0] ts, input logic mq, input logic rd,
                                          input logic wr, input logic ml);
        return {19'd0, st, ce, oe, ts, mq, rd, wr, ml};
    endfunction

    initial begin
        RESET = 1'b1; HALT_REQ = 1'b0; STOP_REQ = 1'b0; MEM_ACCESS = 1'b0;
        MEM_WRITE = 1'b0; MEM_WAIT = 1'b0; OSC_STABLE = 1'b0;
        WAKE = 5'b0; WAKE_MASK = 5'b0;
        step(); step();
        chk("reset_vec", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
        chk("reset_wake_id", {29'd0, WAKE_ID}, 32'd0);
        chk("reset_timeout", {31'd0, WAIT_TIMEOUT}, 32'd0);

        // Read accesses, two full M-cycles
        RESET = 1'b0; MEM_ACCESS = 1'b1; MEM_WRITE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            case ((i + 1) % 4)
                1: chk("read_t1", snap(), exp_v(3'd0, 1, 1, 4'b0010, 1, 1, 0, 0));
                2: chk("read_t2", snap(), exp_v(3'd0, 1, 1, 4'b0100, 1, 1, 0, 0));
                3: chk("read_t3", snap(), exp_v(3'd0, 1, 1, 4'b1000, 1, 1, 0, 1));
                default: chk("read_t0", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
            endcase
        end

        // Write access with 3 wait cycles at T2
        MEM_WRITE = 1'b1;
        step();
        chk("wr_t1", snap(), exp_v(3'd0, 1, 1, 4'b0010, 1, 0, 0, 0));
        MEM_ACCESS = 1'b0; MEM_WAIT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) MEM_WAIT = 1'b0;
            chk("wr_stall_t2", snap(), exp_v(3'd0, 1, 1, 4'b0100, 1, 0, 1, 0));
        end
        step();
        chk("wr_t3", snap(), exp_v(3'd0, 1, 1, 4'b1000, 1, 0, 1, 1));
        step();
        chk("wr_done_t0", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));

        // HALT for 10 cycles, wake via masked source 2 (source 4 is masked off)
        step(); step(); step();
        chk("idle_t3", snap(), exp_v(3'd0, 1, 1, 4'b1000, 0, 0, 0, 1));
        HALT_REQ = 1'b1;
        WAKE = 5'b10100;
        step();
        HALT_REQ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("halt_hold", snap(), exp_v(3'd1, 0, 1, 4'b0001, 0, 0, 0, 0));
            if (i == 9) WAKE_MASK = 5'b00100;
            step();
        end
        chk("halt_wake", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
        chk("halt_wake_id", {29'd0, WAKE_ID}, 32'd2);
        WAKE = 5'b0; WAKE_MASK = 5'b0;

        // STOP has priority over HALT and is taken only at the wrap
        STOP_REQ = 1'b1; HALT_REQ = 1'b1;
        step();
        chk("stop_not_mid", snap(), exp_v(3'd0, 1, 1, 4'b0010, 0, 0, 0, 0));
        step(); step(); step();
        STOP_REQ = 1'b0; HALT_REQ = 1'b0;
        chk("stop_entry", snap(), exp_v(3'd2, 0, 0, 4'b0001, 0, 0, 0, 0));
        WAKE_MASK = 5'b00001;
        step();
        chk("stop_no_wake", snap(), exp_v(3'd2, 0, 0, 4'b0001, 0, 0, 0, 0));
        WAKE = 5'b00001;
        step();
        chk("stop_wake", snap(), exp_v(3'd3, 0, 1, 4'b0001, 0, 0, 0, 0));
        chk("stop_wake_id", {29'd0, WAKE_ID}, 32'd0);
        OSC_STABLE = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("osc_5stable", snap(), exp_v(3'd3, 0, 1, 4'b0001, 0, 0, 0, 0));
        OSC_STABLE = 1'b0;
        step();
        chk("osc_drop", snap(), exp_v(3'd3, 0, 1, 4'b0001, 0, 0, 0, 0));
        OSC_STABLE = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("osc_15stable", snap(), exp_v(3'd3, 0, 1, 4'b0001, 0, 0, 0, 0));
        step();
        chk("osc_resume", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
        OSC_STABLE = 1'b0; WAKE = 5'b0;

        // RESET in the middle of OSC_WAIT
        STOP_REQ = 1'b1;
        step(); step(); step(); step();
        STOP_REQ = 1'b0;
        chk("stop2_entry", snap(), exp_v(3'd2, 0, 0, 4'b0001, 0, 0, 0, 0));
        WAKE = 5'b00001;
        step();
        OSC_STABLE = 1'b1;
        step(); step(); step();
        chk("osc2_wait", snap(), exp_v(3'd3, 0, 1, 4'b0001, 0, 0, 0, 0));
        RESET = 1'b1;
        step();
        chk("reset_mid_osc", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
        RESET = 1'b0; OSC_STABLE = 1'b0; WAKE = 5'b0; WAKE_MASK = 5'b0;

        // RESET in the middle of a stall
        MEM_ACCESS = 1'b1; MEM_WRITE = 1'b1; MEM_WAIT = 1'b1;
        step(); step(); step();
        chk("stall_pre_reset", snap(), exp_v(3'd0, 1, 1, 4'b0100, 1, 0, 1, 0));
        RESET = 1'b1;
        step();
        chk("reset_mid_stall", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
        RESET = 1'b0;

        // Long stall: bounded by WAIT_MAX only when the timeout feature is built
        MEM_WRITE = 1'b0;
        step(); step();
        chk("long_t2", snap(), exp_v(3'd0, 1, 1, 4'b0100, 1, 1, 0, 0));
`ifdef SEQ_WAIT_TIMEOUT_EN
        for (int i = 0; i < 8; i++) step();
        chk("to_still_t2", snap(), exp_v(3'd0, 1, 1, 4'b0100, 1, 1, 0, 0));
        chk("to_not_yet", {31'd0, WAIT_TIMEOUT}, 32'd0);
        step();
        chk("to_advance", snap(), exp_v(3'd0, 1, 1, 4'b1000, 1, 1, 0, 1));
        chk("to_set", {31'd0, WAIT_TIMEOUT}, 32'd1);
        MEM_ACCESS = 1'b0; MEM_WAIT = 1'b0;
        step(); step(); step();
        chk("to_sticky", {31'd0, WAIT_TIMEOUT}, 32'd1);
`else
        for (int i = 0; i < 20; i++) step();
        chk("nto_still_t2", snap(), exp_v(3'd0, 1, 1, 4'b0100, 1, 1, 0, 0));
        chk("nto_flag", {31'd0, WAIT_TIMEOUT}, 32'd0);
        MEM_ACCESS = 1'b0; MEM_WAIT = 1'b0;
        step();
        chk("nto_release", snap(), exp_v(3'd0, 1, 1, 4'b1000, 1, 1, 0, 1));
`endif
        RESET = 1'b1;
        step();
        chk("final_reset", snap(), exp_v(3'd0, 1, 1, 4'b0001, 0, 0, 0, 0));
        chk("final_timeout", {31'd0, WAIT_TIMEOUT}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
